// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and constants for the CPU data-memory responder.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU data-memory request/response bus.
interface data_mem_responder_if #(parameter int ADDR_W = 32);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic ready;
  logic err;
  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: big-endian byte RAM with a word write port, word read and clear-on-reset.
module dmem_byte_array
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WA = $clog2(DEPTH_BYTES / WORD_BYTES)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          we_i,
  input  logic [WA-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [7:0] mem_q [DEPTH_BYTES];
  assign rdata_o = {mem_q[{waddr_i, 2'd0}], mem_q[{waddr_i, 2'd1}],
                    mem_q[{waddr_i, 2'd2}], mem_q[{waddr_i, 2'd3}]};
  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[{waddr_i, 2'd0}] <= wdata_i[31:24];
      mem_q[{waddr_i, 2'd1}] <= wdata_i[23:16];
      mem_q[{waddr_i, 2'd2}] <= wdata_i[15:8];
      mem_q[{waddr_i, 2'd3}] <= wdata_i[7:0];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word load/store responder with programmable wait states and
// misaligned/out-of-range rejection, backed by a big-endian byte array.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input logic clk,
  input logic Reset,
  data_mem_responder_if.slave bus
);
  localparam int WA = $clog2(DEPTH_BYTES / WORD_BYTES);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - WORD_BYTES);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_BYTES % WORD_BYTES != 0) begin : g_depth_chk
    $error("DEPTH_BYTES must be a multiple of 4");
  end
  state_t state_q;
  logic [3:0] wcnt_q;
  logic we_q, ready_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q, mem_rd;
  logic eff_we, to_resp, bad;
  logic [ADDR_W-1:0] eff_addr;
  logic [31:0] eff_wdata;
  // With zero wait states RESP is entered on the accepting edge, so use the live bus then.
  always_comb begin
    eff_we    = state_q == IDLE ? bus.we : we_q;
    eff_addr  = state_q == IDLE ? bus.addr : addr_q;
    eff_wdata = state_q == IDLE ? bus.wdata : wdata_q;
    to_resp   = state_q == IDLE ? bus.req && WAIT_CYCLES == 0 : state_q == WAIT && wcnt_q == 4'd1;
    bad       = eff_addr[1:0] != 2'd0 || eff_addr > MAX_ADDR;
  end
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_arr (
    .clk     (clk),
    .Reset   (Reset),
    .we_i    (to_resp && eff_we && !bad),
    .waddr_i (eff_addr[WA+1:2]),
    .wdata_i (eff_wdata),
    .rdata_o (mem_rd)
  );
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= to_resp;
      err_q   <= to_resp && bad;
      if (to_resp && (bad || !eff_we)) rdata_q <= bad ? ERR_RDATA : mem_rd;
      case (state_q)
        IDLE: if (bus.req) begin
          we_q    <= bus.we;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
          wcnt_q  <= 4'(WAIT_CYCLES);
          state_q <= WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for the responder at WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;
  data_mem_responder_if #(.ADDR_W(32)) b2 ();
  data_mem_responder_if #(.ADDR_W(32)) b0 ();
  data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(2), .ADDR_W(32)) u2 (
    .clk(clk), .Reset(Reset), .bus(b2.slave));
  data_mem_responder #(.DEPTH_BYTES(128), .WAIT_CYCLES(0), .ADDR_W(32)) u0 (
    .clk(clk), .Reset(Reset), .bus(b0.slave));
  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        ld;
  } exp_t;
  exp_t sb[$];
  logic [31:0] mdl [32];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_mdl();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask
  task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.err = a[1:0] != 2'd0 || a > 32'd124;
    e.ld  = !w || e.err;
    e.rd  = e.err ? 32'hDEAD_BEEF : mdl[a[6:2]];
    if (w && !e.err) mdl[a[6:2]] = d;
    sb.push_back(e);
  endtask
  task automatic pop_cmp(input string tag, input logic er, input logic [31:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_err"}, 32'(er), 32'(e.err));
    if (e.ld) check({tag, "_rdata"}, rd, e.rd);
  endtask
  task automatic acc2(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic disturb);
    int n;
    @(negedge clk);
    b2.req = 1'b1; b2.we = w; b2.addr = a; b2.wdata = d;
    push_exp(w, a, d);
    @(posedge clk);
    if (disturb) begin
      #1;
      b2.req = 1'b0; b2.we = ~w; b2.addr = a + 32'd4; b2.wdata = ~d;
    end
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b2.ready) break;
      @(posedge clk);
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    pop_cmp(tag, b2.err, b2.rdata);
    b2.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, b2.ready}, 32'd0);
    check({tag, "_err_idle"}, {31'd0, b2.err}, 32'd0);
  endtask
  initial begin
    logic [31:0] w;
    logic rdy;
    b2.req = 1'b0; b2.we = 1'b0; b2.addr = '0; b2.wdata = '0;
    b0.req = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0;
    clear_mdl();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, b2.ready}, 32'd0);
    check("rst_err", {31'd0, b2.err}, 32'd0);
    check("rst_rdata", b2.rdata, 32'h0);
    check("rst_rdata_w0", b0.rdata, 32'h0);
    Reset = 1'b1;
    acc2("st8", 1'b1, 32'd8, 32'h1234_5678, 1'b0);
    w = 32'h1234_5678;
    for (int i = 0; i < 4; i++) check("byte", {24'd0, u2.u_arr.mem_q[8+i]}, {24'd0, w[31-8*i -: 8]});
    acc2("ld8", 1'b0, 32'd8, 32'h0, 1'b0);
    acc2("ld4", 1'b0, 32'd4, 32'h0, 1'b0);
    acc2("st6_misaligned", 1'b1, 32'd6, 32'hFFFF_FFFF, 1'b0);
    acc2("ld128_range", 1'b0, 32'd128, 32'h0, 1'b0);
    acc2("ld_high_bits", 1'b0, 32'h1000_0008, 32'h0, 1'b0);
    acc2("st_high_bits", 1'b1, 32'h0000_0088, 32'hBAD0_BAD0, 1'b0);
    acc2("ld4_after_err", 1'b0, 32'd4, 32'h0, 1'b0);
    acc2("ld8_after_err", 1'b0, 32'd8, 32'h0, 1'b0);
    acc2("st124_edge", 1'b1, 32'd124, 32'hA5A5_0F0F, 1'b0);
    acc2("ld124_edge", 1'b0, 32'd124, 32'h0, 1'b0);
    acc2("st16_disturb", 1'b1, 32'd16, 32'h0BAD_CAFE, 1'b1);
    acc2("ld16", 1'b0, 32'd16, 32'h0, 1'b0);
    acc2("ld20", 1'b0, 32'd20, 32'h0, 1'b0);
    @(negedge clk);
    b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'd24; b2.wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    b2.req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    clear_mdl();
    check("midrst_rdata", b2.rdata, 32'h0);
    rdy = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      rdy |= b2.ready;
    end
    check("midrst_no_ready", {31'd0, rdy}, 32'd0);
    acc2("ld24_after_rst", 1'b0, 32'd24, 32'h0, 1'b0);
    acc2("ld8_after_rst", 1'b0, 32'd8, 32'h0, 1'b0);
    begin
      logic [31:0] ta [8];
      logic tw [8];
      ta = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'd2, 32'd4};
      tw = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      @(negedge clk);
      b0.req = 1'b1; b0.we = tw[0]; b0.addr = ta[0]; b0.wdata = 32'h1111_0000;
      push_exp(tw[0], ta[0], 32'h1111_0000);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("b2b%0d_ready", k), {31'd0, b0.ready}, 32'd1);
        pop_cmp($sformatf("b2b%0d", k), b0.err, b0.rdata);
        if (k < 7) begin
          b0.we = tw[k+1]; b0.addr = ta[k+1]; b0.wdata = 32'h1111_0000 + 32'(k + 1);
          push_exp(tw[k+1], ta[k+1], 32'h1111_0000 + 32'(k + 1));
        end else b0.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("b2b%0d_gap", k), {31'd0, b0.ready}, 32'd0);
      end
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
